// File: rtl/delay_line_prog.sv
// delay_line_prog: programmable B-bit delay line, 1..MAX_N en-qualified cycles.
// Each stage carries {valid, data}. The output is taken from stage dly_cur-1.
// Changing the clamped delay flushes all valid bits. The sample presented in
// the flush cycle is still captured if en=1.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   en         advance enable (0 = stall, all state holds)
//   dly        requested delay in en-cycles (clamped to 1..MAX_N)
//   in_valid   qualifies in
//   in         data in
//   out_valid  valid bit of the selected stage
//   out        data of the selected stage
//   primed     selected depth has filled since the last reset/flush
//   dly_err    combinational: dly==0 or dly>MAX_N
module delay_line_prog #(
  parameter int unsigned B     = 8,
  parameter int unsigned MAX_N = 16,
  parameter int unsigned DW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] dly,
  input  logic          in_valid,
  input  logic [B-1:0]  in,
  output logic          out_valid,
  output logic [B-1:0]  out,
  output logic          primed,
  output logic          dly_err
);

  logic [MAX_N-1:0] vld_q, vld_d, vld_c;
  logic [B-1:0]     dat_q [MAX_N];
  logic [B-1:0]     dat_d [MAX_N];
  logic [DW-1:0]    dly_cur_q, dly_cur_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic [DW-1:0]    dly_c;
  logic             flush;

  always_comb begin
    dly_err = (dly == '0) || (dly > DW'(MAX_N));
    if (dly == '0)
      dly_c = DW'(1);
    else if (dly > DW'(MAX_N))
      dly_c = DW'(MAX_N);
    else
      dly_c = dly;
  end

  assign flush = (dly_c != dly_cur_q);

  // Flush is applied first, then the shift operates on the flushed view,
  // so the sample captured in a flush cycle is the only valid one left.
  always_comb begin
    vld_c     = flush ? '0 : vld_q;
    vld_d     = vld_c;
    dat_d     = dat_q;
    dly_cur_d = flush ? dly_c : dly_cur_q;
    fill_d    = flush ? '0 : fill_q;
    if (en) begin
      vld_d[0] = in_valid;
      dat_d[0] = in;
      for (int unsigned i = 1; i < MAX_N; i++) begin
        vld_d[i] = vld_c[i-1];
        dat_d[i] = dat_q[i-1];
      end
      if (fill_d < dly_cur_d)
        fill_d = fill_d + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      for (int unsigned i = 0; i < MAX_N; i++)
        dat_q[i] <= '0;
      fill_q    <= '0;
      dly_cur_q <= dly_c;
    end else begin
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      fill_q    <= fill_d;
      dly_cur_q <= dly_cur_d;
    end
  end

  // Output select: registers only, no path from in.
  always_comb begin
    out       = '0;
    out_valid = 1'b0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      if (dly_cur_q == DW'(i + 1)) begin
        out       = dat_q[i];
        out_valid = vld_q[i];
      end
    end
  end

  assign primed = (fill_q == dly_cur_q);

endmodule

// File: tb/tb_delay_line_prog.sv
module tb_delay_line_prog;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] dly;
  logic       in_valid;
  logic [7:0] in;
  logic       out_valid;
  logic [7:0] out;
  logic       primed;
  logic       dly_err;

  delay_line_prog #(.B(8), .MAX_N(16), .DW(5)) dut (
    .clk(clk), .rst(rst), .en(en), .dly(dly), .in_valid(in_valid), .in(in),
    .out_valid(out_valid), .out(out), .primed(primed), .dly_err(dly_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit v; logic [7:0] d; bit k; } ent_t;
  typedef struct { bit v; logic [7:0] d; bit k; bit p; } exp_t;

  ent_t hist [16];
  int   mdly;
  int   mfill;
  exp_t sbq [$];
  int   nv;
  int   nm;

  function automatic int clampd(input int dl);
    if (dl == 0) return 1;
    if (dl > 16) return 16;
    return dl;
  endfunction

  // Drive one cycle, advance the reference model at the edge, push expectation.
  task automatic step(input bit r, input bit e, input int dl, input bit iv,
                      input logic [7:0] di);
    int   c;
    exp_t x;
    rst = r; en = e; dly = 5'(dl); in_valid = iv; in = di;
    @(posedge clk);
    c = clampd(dl);
    if (r) begin
      for (int i = 0; i < 16; i++) hist[i] = '{1'b0, 8'h00, 1'b1};
      mdly = c; mfill = 0;
    end else begin
      if (c != mdly) begin
        mdly = c; mfill = 0;
        for (int i = 0; i < 16; i++) begin hist[i].v = 1'b0; hist[i].k = 1'b0; end
      end
      if (e) begin
        for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = '{iv, di, iv};
        if (mfill < mdly) mfill++;
      end
    end
    x.v = hist[mdly-1].v; x.d = hist[mdly-1].d; x.k = hist[mdly-1].k;
    x.p = (mfill == mdly);
    sbq.push_back(x);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    int   rise;
    rise = -1;
    step(1, 1, 4, 1, 8'hAA);
    step(1, 1, 4, 1, 8'hBB);
    for (int c = 0; c < 2; c++) begin
      x = sbq.pop_front(); nv++;
      if (out_valid !== x.v || primed !== x.p || out !== 8'h00) begin
        nm++;
        $display("FAIL reset hold c%0d: got v=%b d=%h p=%b want v=0 d=00 p=0",
                 c, out_valid, out, primed);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      step(0, 1, 4, 0, 8'h00);
      x = sbq.pop_front(); nv++;
      if (out_valid !== x.v || primed !== x.p || (x.k && out !== x.d)) begin
        nm++;
        $display("FAIL reset run c%0d: got v=%b d=%h p=%b want v=%b d=%h p=%b",
                 c, out_valid, out, primed, x.v, x.d, x.p);
      end
      if (primed === 1'b1 && rise < 0) rise = c;
    end
    nv++;
    if (rise != 4) begin
      nm++;
      $display("FAIL primed rise: got cycle %0d want cycle 4", rise);
    end
  endtask

  task automatic test_latency(input int dl);
    exp_t x;
    step(1, 0, dl, 0, 8'h00);
    void'(sbq.pop_front());
    for (int c = 0; c < dl + 6; c++) begin
      step(0, 1, dl, 1, 8'(c + 1));
      x = sbq.pop_front(); nv++;
      if (out_valid !== x.v || primed !== x.p || (x.k && out !== x.d)) begin
        nm++;
        $display("FAIL latency d%0d c%0d: got v=%b d=%h p=%b want v=%b d=%h p=%b",
                 dl, c, out_valid, out, primed, x.v, x.d, x.p);
      end
    end
    // First output (value 1) is due in cycle dl; we are now at cycle dl+6.
  endtask

  task automatic test_stall();
    exp_t x;
    logic [9:0] frz;
    step(1, 0, 3, 0, 8'h00);
    void'(sbq.pop_front());
    step(0, 1, 3, 1, 8'd10); void'(sbq.pop_front());
    step(0, 1, 3, 1, 8'd11); void'(sbq.pop_front());
    frz = {out_valid, primed, out};
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 3, 1, 8'($urandom_range(255)));
      x = sbq.pop_front(); nv++;
      if ({out_valid, primed, out} !== frz || out_valid !== x.v || primed !== x.p) begin
        nm++;
        $display("FAIL stall c%0d: got v=%b d=%h p=%b want frozen %h",
                 c, out_valid, out, primed, frz);
      end
    end
    for (int c = 0; c < 6; c++) begin
      step(0, 1, 3, (c < 2), 8'(12 + c));
      x = sbq.pop_front(); nv++;
      if (out_valid !== x.v || primed !== x.p || (x.k && out !== x.d)) begin
        nm++;
        $display("FAIL stall resume c%0d: got v=%b d=%h p=%b want v=%b d=%h p=%b",
                 c, out_valid, out, primed, x.v, x.d, x.p);
      end
      if (c == 0 && (out_valid !== 1'b1 || out !== 8'd10)) begin
        nm++;
        $display("FAIL stall third edge: got v=%b d=%h want v=1 d=0a", out_valid, out);
      end
      if (c == 0) nv++;
    end
  endtask

  task automatic test_change();
    exp_t x;
    step(1, 0, 8, 0, 8'h00);
    void'(sbq.pop_front());
    for (int c = 0; c < 12; c++) begin
      step(0, 1, 8, 1, 8'(c + 1));
      void'(sbq.pop_front());
    end
    for (int c = 0; c < 8; c++) begin
      step(0, 1, 2, 1, (c == 0) ? 8'h55 : 8'(8'h60 + c));
      x = sbq.pop_front(); nv++;
      if (out_valid !== x.v || primed !== x.p || (x.k && out !== x.d)) begin
        nm++;
        $display("FAIL change c%0d: got v=%b d=%h p=%b want v=%b d=%h p=%b",
                 c, out_valid, out, primed, x.v, x.d, x.p);
      end
      if (out_valid === 1'b1 && out >= 8'd1 && out <= 8'd12) begin
        nm++;
        $display("FAIL change stale c%0d: got d=%h want no pre-change sample", c, out);
      end
    end
  endtask

  task automatic test_clamp();
    exp_t x;
    int   dv [6];
    bit   ev [6];
    dv = '{0, 1, 16, 17, 20, 31};
    ev = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      dly = 5'(dv[i]);
      #1; nv++;
      if (dly_err !== ev[i]) begin
        nm++;
        $display("FAIL dly_err dly=%0d: got %b want %b", dv[i], dly_err, ev[i]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(1, 0, (k == 0) ? 0 : 20, 0, 8'h00);
      void'(sbq.pop_front());
      for (int c = 0; c < 20; c++) begin
        step(0, 1, (k == 0) ? 0 : 20, 1, 8'(8'h80 + c));
        x = sbq.pop_front(); nv++;
        if (out_valid !== x.v || primed !== x.p || (x.k && out !== x.d)) begin
          nm++;
          $display("FAIL clamp k%0d c%0d: got v=%b d=%h p=%b want v=%b d=%h p=%b",
                   k, c, out_valid, out, primed, x.v, x.d, x.p);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    step(1, 0, 5, 0, 8'h00);
    void'(sbq.pop_front());
    for (int c = 0; c < 8; c++) begin
      step(0, 1, 5, 1, 8'(8'hC0 + c));
      void'(sbq.pop_front());
    end
    step(1, 1, 5, 1, 8'hEE);
    x = sbq.pop_front(); nv++;
    if (out_valid !== 1'b0 || out !== 8'h00 || primed !== 1'b0 || x.p) begin
      nm++;
      $display("FAIL reset mid: got v=%b d=%h p=%b want v=0 d=00 p=0",
               out_valid, out, primed);
    end
    for (int c = 0; c < 8; c++) begin
      step(0, 1, 5, 1, 8'(8'hD0 + c));
      x = sbq.pop_front(); nv++;
      if (out_valid !== x.v || primed !== x.p || (x.k && out !== x.d) ||
          (out_valid === 1'b1 && out[7:4] == 4'hC)) begin
        nm++;
        $display("FAIL reset mid c%0d: got v=%b d=%h p=%b want v=%b d=%h p=%b",
                 c, out_valid, out, primed, x.v, x.d, x.p);
      end
    end
  endtask

  task automatic test_random();
    exp_t x;
    int   dl;
    dl = 6;
    step(1, 0, dl, 0, 8'h00);
    void'(sbq.pop_front());
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(19) == 0) dl = $urandom_range(31);
      step(($urandom_range(49) == 0), ($urandom_range(3) != 0), dl,
           1'($urandom_range(1)), 8'($urandom_range(255)));
      x = sbq.pop_front(); nv++;
      if (out_valid !== x.v || primed !== x.p || (x.k && out !== x.d)) begin
        nm++;
        $display("FAIL random c%0d: got v=%b d=%h p=%b want v=%b d=%h p=%b",
                 c, out_valid, out, primed, x.v, x.d, x.p);
      end
    end
  endtask

  initial begin
    nv = 0; nm = 0;
    rst = 1'b1; en = 1'b0; dly = 5'd4; in_valid = 1'b0; in = 8'h00;
    mdly = 1; mfill = 0;
    test_reset();
    test_latency(4);
    test_latency(16);
    test_latency(1);
    test_stall();
    test_change();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end

endmodule
